// File: rtl/m_mac_pipe.sv
// m_mac_pipe: 3-stage handshaked multiply-add / accumulate pipeline.
// Optional clamp-on-overflow built when M_MAC_PIPE_SATURATE_EN is defined.
module m_mac_pipe #(
  parameter int K_W = 16,
  parameter int B_W = 16,
  parameter int C_W = 32,
  parameter int Y_W = 32
) (
  input  logic           w_clock,
  input  logic           w_rst_n,
  input  logic           w_in_valid,
  output logic           w_in_ready,
  input  logic [K_W-1:0] w_k,
  input  logic [B_W-1:0] w_b,
  input  logic [C_W-1:0] w_c,
  input  logic [1:0]     w_mode,
  output logic           r_y_valid,
  input  logic           w_out_ready,
  output logic [Y_W-1:0] r_y,
  output logic           r_ovf,
  output logic [Y_W-1:0] r_acc
);

  localparam int P_W = K_W + B_W;
  localparam int S_W = ((P_W > Y_W) ? P_W : Y_W) + 1;

  typedef struct packed {
    logic           v;
    logic [K_W-1:0] k;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
    logic [1:0]     mode;
  } s1_t;

  typedef struct packed {
    logic           v;
    logic [P_W-1:0] p;
    logic [C_W-1:0] c;
    logic [1:0]     mode;
  } s2_t;

  s1_t            s1_q, s1_d;
  s2_t            s2_q, s2_d;
  logic           y_valid_q, y_valid_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           ovf_q, ovf_d;
  logic [Y_W-1:0] acc_q, acc_d;

  logic           stall;
  logic           use_acc;
  logic           upd_acc;
  logic [S_W-1:0] p_x;
  logic [S_W-1:0] a_x;
  logic [S_W-1:0] s;
  logic           ovf_res;
  logic [Y_W-1:0] y_res;

  assign stall      = y_valid_q & ~w_out_ready;
  assign w_in_ready = ~stall;

  assign r_y_valid = y_valid_q;
  assign r_y       = y_q;
  assign r_ovf     = ovf_q;
  assign r_acc     = acc_q;

  // Decode the S3 mode: which addend, and whether acc follows the result
  always_comb begin
    use_acc = 1'b0;
    upd_acc = 1'b0;
    unique case (1'b1)
      (s2_q.mode == 2'b01): begin
        use_acc = 1'b1;
        upd_acc = 1'b1;
      end
      (s2_q.mode == 2'b10): begin
        upd_acc = 1'b1;
      end
      default: ;
    endcase
  end

  // S3 sum; any bit above Y_W means the result does not fit
  always_comb begin
    p_x     = S_W'(s2_q.p);
    a_x     = use_acc ? S_W'(acc_q) : S_W'(s2_q.c);
    s       = p_x + a_x;
    ovf_res = |s[S_W-1:Y_W];
`ifdef M_MAC_PIPE_SATURATE_EN
    y_res   = ovf_res ? {Y_W{1'b1}} : s[Y_W-1:0];
`else
    y_res   = s[Y_W-1:0];
`endif
  end

  // Advance all stages together unless the output is stalled
  always_comb begin
    s1_d      = s1_q;
    s2_d      = s2_q;
    y_valid_d = y_valid_q;
    y_d       = y_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    if (!stall) begin
      s1_d.v    = w_in_valid;
      s1_d.k    = w_k;
      s1_d.b    = w_b;
      s1_d.c    = w_c;
      s1_d.mode = w_mode;
      s2_d.v    = s1_q.v;
      s2_d.p    = P_W'(s1_q.k) * P_W'(s1_q.b);
      s2_d.c    = s1_q.c;
      s2_d.mode = s1_q.mode;
      y_valid_d = s2_q.v;
      if (s2_q.v) begin
        y_d   = y_res;
        ovf_d = ovf_res;
        if (upd_acc) begin
          acc_d = y_res;
        end
      end
    end
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge w_clock) begin
    if (!w_rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_m_mac_pipe.sv
// tb_m_mac_pipe: directed vector table plus stall and reset sequences.
// Expected values follow M_MAC_PIPE_SATURATE_EN when defined.
module tb_m_mac_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] k;
  logic [15:0] b;
  logic [31:0] c;
  logic [1:0]  mode;
  logic        y_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
  logic [31:0] acc;

  int n_chk;
  int n_fail;

  m_mac_pipe dut (
    .w_clock     (clk),
    .w_rst_n     (rst_n),
    .w_in_valid  (in_valid),
    .w_in_ready  (in_ready),
    .w_k         (k),
    .w_b         (b),
    .w_c         (c),
    .w_mode      (mode),
    .r_y_valid   (y_valid),
    .w_out_ready (out_ready),
    .r_y         (y),
    .r_ovf       (ovf),
    .r_acc       (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] k;
    logic [15:0] b;
    logic [31:0] c;
    logic [1:0]  mode;
    logic [31:0] ey;
    logic        eovf;
    logic [31:0] eacc;
  } vec_t;

  localparam int N = 13;
  vec_t tv[N];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] kk,
                       input logic [15:0] bb, input logic [31:0] cc,
                       input logic [1:0] mm);
    in_valid = v;
    k        = kk;
    b        = bb;
    c        = cc;
    mode     = mm;
  endtask

  initial begin
    int sent;
    int recv;
    int stall_left;
    bit seen;
    bit prev_st;
    bit in_hs;
    logic [31:0] held_y;

    n_chk  = 0;
    n_fail = 0;

    tv[0]  = '{16'd3, 16'd1, 32'd2, 2'b00, 32'd5, 1'b0, 32'd0};
    tv[1]  = '{16'd3, 16'd3, 32'd4, 2'b00, 32'd13, 1'b0, 32'd0};
    tv[2]  = '{16'd3, 16'd5, 32'd6, 2'b00, 32'd21, 1'b0, 32'd0};
    tv[3]  = '{16'd3, 16'd7, 32'd8, 2'b00, 32'd29, 1'b0, 32'd0};
    tv[4]  = '{16'd2, 16'd10, 32'd100, 2'b10, 32'd120, 1'b0, 32'd120};
    tv[5]  = '{16'd2, 16'd5, 32'd0, 2'b01, 32'd130, 1'b0, 32'd130};
    tv[6]  = '{16'd4, 16'd1, 32'd999, 2'b01, 32'd134, 1'b0, 32'd134};
    tv[7]  = '{16'd2, 16'd3, 32'd4, 2'b11, 32'd10, 1'b0, 32'd134};
`ifdef M_MAC_PIPE_SATURATE_EN
    tv[8]  = '{16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 2'b00,
               32'hFFFFFFFF, 1'b1, 32'd134};
`else
    tv[8]  = '{16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 2'b00,
               32'hFFFE0000, 1'b1, 32'd134};
`endif
    tv[9]  = '{16'd1, 16'd1, 32'd1, 2'b00, 32'd2, 1'b0, 32'd134};
    tv[10] = '{16'hFFFF, 16'hFFFF, 32'd0, 2'b01,
               32'hFFFE0087, 1'b0, 32'hFFFE0087};
`ifdef M_MAC_PIPE_SATURATE_EN
    tv[11] = '{16'd4, 16'h8000, 32'd0, 2'b01,
               32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};
    tv[12] = '{16'd0, 16'd0, 32'd5, 2'b00, 32'd5, 1'b0, 32'hFFFFFFFF};
`else
    tv[11] = '{16'd4, 16'h8000, 32'd0, 2'b01,
               32'h00000087, 1'b1, 32'h00000087};
    tv[12] = '{16'd0, 16'd0, 32'd5, 2'b00, 32'd5, 1'b0, 32'h00000087};
`endif

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, 2'b00);
    step();
    step();
    rst_n = 1'b1;
    chk("rst_valid", 64'(y_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_acc", 64'(acc), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    for (int t = 0; t < N + 2; t++) begin
      if (t < N) drive(1'b1, tv[t].k, tv[t].b, tv[t].c, tv[t].mode);
      else drive(1'b0, '0, '0, '0, 2'b00);
      step();
      if (t >= 2) begin
        chk($sformatf("tv%0d_valid", t - 2), 64'(y_valid), 64'd1);
        chk($sformatf("tv%0d_y", t - 2), 64'(y), 64'(tv[t-2].ey));
        chk($sformatf("tv%0d_ovf", t - 2), 64'(ovf), 64'(tv[t-2].eovf));
        chk($sformatf("tv%0d_acc", t - 2), 64'(acc), 64'(tv[t-2].eacc));
      end else begin
        chk($sformatf("fill%0d_valid", t), 64'(y_valid), 64'd0);
      end
    end
    drive(1'b0, '0, '0, '0, 2'b00);
    step();
    chk("drain_valid", 64'(y_valid), 64'd0);

    sent       = 0;
    recv       = 0;
    stall_left = 0;
    seen       = 1'b0;
    prev_st    = 1'b0;
    held_y     = '0;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      if (!seen && y_valid) begin
        seen       = 1'b1;
        stall_left = 4;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (sent < 6) drive(1'b1, 16'd1, 16'(sent), 32'd1000, 2'b00);
      else drive(1'b0, '0, '0, '0, 2'b00);
      #1;
      if (y_valid && !out_ready) begin
        chk("stall_ready", 64'(in_ready), 64'd0);
        if (prev_st) chk("stall_hold_y", 64'(y), 64'(held_y));
        held_y  = y;
        prev_st = 1'b1;
      end else begin
        prev_st = 1'b0;
      end
      if (y_valid && out_ready) begin
        chk($sformatf("stream%0d_y", recv), 64'(y), 64'(1000 + recv));
        recv++;
      end
      in_hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (in_hs) sent++;
    end
    out_ready = 1'b1;
    chk("stream_count", 64'(recv), 64'd6);
    chk("stream_sent", 64'(sent), 64'd6);
    drive(1'b0, '0, '0, '0, 2'b00);
    step();
    chk("stream_nodup", 64'(y_valid), 64'd0);

    drive(1'b1, 16'd5, 16'd5, 32'd5, 2'b01);
    step();
    drive(1'b1, 16'd6, 16'd6, 32'd6, 2'b01);
    step();
    drive(1'b0, '0, '0, '0, 2'b00);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(y_valid), 64'd0);
    chk("mid_rst_acc", 64'(acc), 64'd0);
    chk("mid_rst_y", 64'(y), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_valid", i), 64'(y_valid), 64'd0);
    end
    chk("post_rst_acc", 64'(acc), 64'd0);
    drive(1'b1, 16'd3, 16'd2, 32'd1, 2'b00);
    step();
    drive(1'b0, '0, '0, '0, 2'b00);
    chk("lat1_valid", 64'(y_valid), 64'd0);
    step();
    chk("lat2_valid", 64'(y_valid), 64'd0);
    step();
    chk("lat3_valid", 64'(y_valid), 64'd1);
    chk("lat3_y", 64'(y), 64'd7);
    chk("lat3_ovf", 64'(ovf), 64'd0);
    step();
    chk("lat4_valid", 64'(y_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
